// File: rtl/wb_trace_pkg.sv
// Shared definitions for the writeback trace buffer: entry layout,
// frame constants, serializer state encoding and the frame byte mux.
package wb_trace_pkg;

  localparam int FRAME_BYTES = 7;
  localparam logic [2:0] HDR_TAG = 3'b101;
  localparam int ENTRY_W = 49;

  // One captured register-file write.
  typedef struct packed {
    logic [4:0]  wreg;
    logic [11:0] pc;
    logic [31:0] data;
  } trace_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } ser_state_t;

  // Byte idx of the outgoing frame for entry e (header, pc, data MSB first).
  function automatic logic [7:0] frame_byte(input trace_entry_t e, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0: b = {HDR_TAG, e.wreg};
      3'd1: b = {4'b0000, e.pc[11:8]};
      3'd2: b = e.pc[7:0];
      3'd3: b = e.data[31:24];
      3'd4: b = e.data[23:16];
      3'd5: b = e.data[15:8];
      3'd6: b = e.data[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular-buffer FIFO with a combinational head read. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 49
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_W-1:0]       din,
  output logic [ENTRY_W-1:0]       dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [AW:0]        level_reg;
  logic               do_push;
  logic               do_pop;

  assign full    = (level_reg == (AW+1)'(DEPTH));
  assign empty   = (level_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];
  assign level   = level_reg;

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Snoops register-file writebacks into a FIFO and serializes each entry as
// a 7-byte frame on a valid/ready byte stream. Overflow never stalls the
// core: excess captures are dropped and counted.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter bit FILTER_R0 = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   trace_en,
  input  logic                   wb_en,
  input  logic [4:0]             wb_reg,
  input  logic [31:0]            wb_data,
  input  logic [11:0]            wb_pc,
  input  logic                   clear_stats,
  output logic [7:0]             out_byte,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             drop_count,
  output logic                   overflow
);

  ser_state_t         state_reg;
  logic [2:0]         idx_reg;
  trace_entry_t       frame_reg;
  logic [7:0]         out_byte_reg;
  logic               out_valid_reg;
  logic [7:0]         drop_count_reg;
  logic               overflow_reg;

  logic               capture;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               drop;
  logic [ENTRY_W-1:0] fifo_dout;
  trace_entry_t       head_entry;
  trace_entry_t       new_entry;

  assign capture    = trace_en && wb_en && !(FILTER_R0 && (wb_reg == 5'd0));
  assign fifo_pop   = (state_reg == ST_IDLE) && !fifo_empty;
  assign drop       = capture && fifo_full && !fifo_pop;
  assign new_entry  = '{wreg: wb_reg, pc: wb_pc, data: wb_data};
  assign head_entry = trace_entry_t'(fifo_dout);

  trace_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (capture),
    .pop   (fifo_pop),
    .din   (new_entry),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Serializer: load the head when idle, then walk the 7 frame bytes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= 3'd0;
      frame_reg     <= '0;
      out_byte_reg  <= 8'h00;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          out_valid_reg <= 1'b0;
          out_byte_reg  <= 8'h00;
          if (!fifo_empty) begin
            frame_reg     <= head_entry;
            idx_reg       <= 3'd0;
            out_byte_reg  <= frame_byte(head_entry, 3'd0);
            out_valid_reg <= 1'b1;
            state_reg     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (idx_reg == 3'(FRAME_BYTES - 1)) begin
              out_valid_reg <= 1'b0;
              out_byte_reg  <= 8'h00;
              state_reg     <= ST_IDLE;
            end else begin
              idx_reg      <= idx_reg + 3'd1;
              out_byte_reg <= frame_byte(frame_reg, idx_reg + 3'd1);
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Drop statistics; a clear coinciding with a drop leaves exactly one drop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count_reg <= 8'd0;
      overflow_reg   <= 1'b0;
    end else if (clear_stats) begin
      drop_count_reg <= drop ? 8'd1 : 8'd0;
      overflow_reg   <= drop;
    end else if (drop) begin
      if (drop_count_reg != 8'hFF) drop_count_reg <= drop_count_reg + 8'd1;
      overflow_reg <= 1'b1;
    end
  end

  assign out_byte   = out_byte_reg;
  assign out_valid  = out_valid_reg;
  assign drop_count = drop_count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_wb_trace_buffer;

  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        trace_en = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic [11:0] wb_pc = '0;
  logic        clear_stats = 1'b0;
  logic        out_ready = 1'b0;

  logic [7:0]  out_byte;
  logic        out_valid;
  logic [4:0]  level;
  logic [7:0]  drop_count;
  logic        overflow;

  logic [7:0]  nf_byte;
  logic        nf_valid;
  logic [4:0]  nf_level;
  logic [7:0]  nf_drop;
  logic        nf_ovf;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [48:0] m_q[$];
  bit          m_busy;
  int          m_pos;
  logic [7:0]  m_frame[7];
  int          m_drop;
  bit          m_ovf;

  always #5 clock = ~clock;

  wb_trace_buffer #(.DEPTH(DEPTH), .FILTER_R0(1'b1)) dut (
    .clock(clock), .reset(reset), .trace_en(trace_en), .wb_en(wb_en),
    .wb_reg(wb_reg), .wb_data(wb_data), .wb_pc(wb_pc), .clear_stats(clear_stats),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .drop_count(drop_count), .overflow(overflow)
  );

  wb_trace_buffer #(.DEPTH(DEPTH), .FILTER_R0(1'b0)) dut_nf (
    .clock(clock), .reset(reset), .trace_en(trace_en), .wb_en(wb_en),
    .wb_reg(wb_reg), .wb_data(wb_data), .wb_pc(wb_pc), .clear_stats(clear_stats),
    .out_byte(nf_byte), .out_valid(nf_valid), .out_ready(out_ready),
    .level(nf_level), .drop_count(nf_drop), .overflow(nf_ovf)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_q.delete();
    m_busy = 0;
    m_pos  = 0;
    m_drop = 0;
    m_ovf  = 0;
  endtask

  // One clock edge of the reference model, from the sampled inputs.
  task automatic model_step();
    bit cap, pop, full_pre, dropped;
    logic [48:0] e;
    if (reset) begin
      model_reset();
      return;
    end
    cap      = trace_en && wb_en && (wb_reg != 5'd0);
    full_pre = (m_q.size() == DEPTH);
    pop      = !m_busy && (m_q.size() > 0);
    dropped  = 0;
    if (m_busy && out_ready) begin
      if (m_pos == 6) m_busy = 0;
      else m_pos++;
    end
    if (pop) begin
      e = m_q.pop_front();
      m_frame[0] = {3'b101, e[48:44]};
      m_frame[1] = {4'h0, e[43:40]};
      m_frame[2] = e[39:32];
      m_frame[3] = e[31:24];
      m_frame[4] = e[23:16];
      m_frame[5] = e[15:8];
      m_frame[6] = e[7:0];
      m_busy = 1;
      m_pos  = 0;
    end
    if (cap) begin
      if (!full_pre || pop) m_q.push_back({wb_reg, wb_pc, wb_data});
      else dropped = 1;
    end
    if (clear_stats) begin
      m_drop = dropped ? 1 : 0;
      m_ovf  = dropped;
    end else if (dropped) begin
      if (m_drop < 255) m_drop++;
      m_ovf = 1;
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wb_en = 1'b0;
    trace_en = 1'b1;
    clear_stats = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%0b want=0", out_valid); else n_pass++;
    n_total++; if (out_byte !== 8'h00) $display("FAIL reset_byte got=%h want=00", out_byte); else n_pass++;
    n_total++; if (level !== 5'd0) $display("FAIL reset_level got=%0d want=0", level); else n_pass++;
    n_total++; if (drop_count !== 8'd0) $display("FAIL reset_drop got=%0d want=0", drop_count); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got=%0b want=0", overflow); else n_pass++;
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic [7:0] exp[7];
    exp = '{8'hA3, 8'h00, 8'h12, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_reset();
    out_ready = 1'b1;
    wb_en = 1'b1; wb_reg = 5'd3; wb_pc = 12'h012; wb_data = 32'hDEADBEEF;
    cyc();
    wb_en = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL single_latency_t0 got=%0b want=0", out_valid); else n_pass++;
    cyc();
    for (int k = 0; k < 7; k++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_byte !== exp[k])
        $display("FAIL single_b%0d got=%0b/%h want=1/%h", k, out_valid, out_byte, exp[k]);
      else n_pass++;
      cyc();
    end
    n_total++; if (out_valid !== 1'b0) $display("FAIL single_end_valid got=%0b want=0", out_valid); else n_pass++;
    n_total++; if (level !== 5'd0) $display("FAIL single_end_level got=%0d want=0", level); else n_pass++;
    $display("test_single done");
  endtask

  task automatic test_filter();
    logic [7:0] exp[7];
    logic [7:0] got[$];
    bit saw_valid;
    exp = '{8'hA0, 8'h03, 8'hC5, 8'h01, 8'h23, 8'h45, 8'h67};
    saw_valid = 0;
    do_reset();
    out_ready = 1'b1;
    wb_en = 1'b1; wb_reg = 5'd0; wb_pc = 12'h3C5; wb_data = 32'h01234567;
    cyc();
    wb_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid === 1'b1 || level !== 5'd0) saw_valid = 1;
      if (nf_valid === 1'b1) got.push_back(nf_byte);
      cyc();
    end
    n_total++; if (saw_valid) $display("FAIL filter_r0 got=activity want=none"); else n_pass++;
    n_total++; if (got.size() != 7) $display("FAIL filter_nf_count got=%0d want=7", got.size()); else n_pass++;
    for (int k = 0; k < 7 && k < got.size(); k++) begin
      n_total++;
      if (got[k] !== exp[k]) $display("FAIL filter_nf_b%0d got=%h want=%h", k, got[k], exp[k]);
      else n_pass++;
    end
    $display("test_filter done");
  endtask

  task automatic test_backpressure();
    logic [7:0] tail[4];
    tail = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_reset();
    out_ready = 1'b1;
    wb_en = 1'b1; wb_reg = 5'd7; wb_pc = 12'hABC; wb_data = 32'hDEADBEEF;
    cyc();
    wb_en = 1'b0;
    cyc();
    cyc(); cyc(); cyc();
    n_total++; if (out_byte !== 8'hDE) $display("FAIL bp_reach_b3 got=%h want=de", out_byte); else n_pass++;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      n_total++;
      if (out_valid !== 1'b1 || out_byte !== 8'hDE)
        $display("FAIL bp_hold_%0d got=%0b/%h want=1/de", c, out_valid, out_byte);
      else n_pass++;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_byte !== tail[k])
        $display("FAIL bp_tail_%0d got=%0b/%h want=1/%h", k, out_valid, out_byte, tail[k]);
      else n_pass++;
      cyc();
    end
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_end got=%0b want=0", out_valid); else n_pass++;
    $display("test_backpressure done");
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      wb_en = 1'b1; wb_reg = 5'($urandom_range(31, 1));
      wb_pc = 12'($urandom); wb_data = $urandom;
      cyc();
    end
    wb_en = 1'b0;
    n_total++; if (level !== 5'd16) $display("FAIL ovf_level got=%0d want=16", level); else n_pass++;
    n_total++; if (drop_count !== 8'd3) $display("FAIL ovf_drop got=%0d want=3", drop_count); else n_pass++;
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got=%0b want=1", overflow); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL ovf_ser_busy got=%0b want=1", out_valid); else n_pass++;
    clear_stats = 1'b1;
    cyc();
    clear_stats = 1'b0;
    n_total++; if (drop_count !== 8'd0 || overflow !== 1'b0)
      $display("FAIL ovf_clear got=%0d/%0b want=0/0", drop_count, overflow); else n_pass++;
    $display("test_overflow done");
  endtask

  task automatic test_full_pushpop();
    int guard;
    out_ready = 1'b1;
    guard = 0;
    do begin
      cyc();
      guard++;
    end while (m_busy && guard < 20);
    n_total++; if (out_valid !== 1'b0 || level !== 5'd16)
      $display("FAIL fpp_idle got=%0b/%0d want=0/16", out_valid, level); else n_pass++;
    out_ready = 1'b0;
    wb_en = 1'b1; wb_reg = 5'd5; wb_pc = 12'h111; wb_data = 32'h55AA55AA;
    cyc();
    wb_en = 1'b0;
    n_total++; if (level !== 5'd16) $display("FAIL fpp_level got=%0d want=16", level); else n_pass++;
    n_total++; if (drop_count !== 8'd0) $display("FAIL fpp_drop got=%0d want=0", drop_count); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL fpp_load got=%0b want=1", out_valid); else n_pass++;
    // Clear and drop in the same cycle: one drop survives.
    clear_stats = 1'b1; wb_en = 1'b1;
    cyc();
    clear_stats = 1'b0;
    n_total++; if (drop_count !== 8'd1 || overflow !== 1'b1)
      $display("FAIL clear_vs_drop got=%0d/%0b want=1/1", drop_count, overflow); else n_pass++;
    for (int c = 0; c < 300; c++) cyc();
    wb_en = 1'b0;
    n_total++; if (drop_count !== 8'd255) $display("FAIL drop_saturate got=%0d want=255", drop_count); else n_pass++;
    n_total++; if (overflow !== 1'b1 || level !== 5'd16)
      $display("FAIL drop_sat_state got=%0b/%0d want=1/16", overflow, level); else n_pass++;
    $display("test_full_pushpop done");
  endtask

  task automatic test_async_reset();
    logic [7:0] exp[7];
    exp = '{8'hA2, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    out_ready = 1'b1;
    wb_en = 1'b1; wb_reg = 5'd9; wb_pc = 12'h456; wb_data = 32'hCAFEF00D;
    cyc();
    wb_reg = 5'd10;
    cyc();
    wb_en = 1'b0;
    cyc(); cyc(); cyc(); cyc();
    n_total++; if (out_byte !== 8'hFE || level !== 5'd1)
      $display("FAIL areset_pre got=%h/%0d want=fe/1", out_byte, level); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_total++; if (out_valid !== 1'b0 || level !== 5'd0)
      $display("FAIL areset_immediate got=%0b/%0d want=0/0", out_valid, level); else n_pass++;
    #1;
    reset = 1'b0;
    wb_en = 1'b1; wb_reg = 5'd2; wb_pc = 12'h001; wb_data = 32'h11223344;
    cyc();
    wb_en = 1'b0;
    cyc();
    for (int k = 0; k < 7; k++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_byte !== exp[k])
        $display("FAIL areset_frame_b%0d got=%0b/%h want=1/%h", k, out_valid, out_byte, exp[k]);
      else n_pass++;
      cyc();
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      trace_en    = ($urandom % 8) != 0;
      wb_en       = (c < 750) ? (($urandom % 3) == 0) : (($urandom % 12) == 0);
      wb_reg      = 5'($urandom % 32);
      wb_pc       = 12'($urandom);
      wb_data     = $urandom;
      out_ready   = (c < 400) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      clear_stats = ($urandom % 97) == 0;
      cyc();
      n_total++;
      if (out_valid !== m_busy) $display("FAIL rnd_valid c=%0d got=%0b want=%0b", c, out_valid, m_busy);
      else n_pass++;
      if (m_busy) begin
        n_total++;
        if (out_byte !== m_frame[m_pos]) $display("FAIL rnd_byte c=%0d got=%h want=%h", c, out_byte, m_frame[m_pos]);
        else n_pass++;
      end
      n_total++;
      if (level !== 5'(m_q.size())) $display("FAIL rnd_level c=%0d got=%0d want=%0d", c, level, m_q.size());
      else n_pass++;
      n_total++;
      if (drop_count !== 8'(m_drop) || overflow !== m_ovf)
        $display("FAIL rnd_stats c=%0d got=%0d/%0b want=%0d/%0b", c, drop_count, overflow, m_drop, m_ovf);
      else n_pass++;
    end
    wb_en = 1'b0; clear_stats = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_filter();
    test_backpressure();
    test_overflow();
    test_full_pushpop();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
Debug capture stage downstream of the processor/regfile writeback port. It snoops every register-file write (write enable, destination register, write data, current instruction address) and queues it in an on-chip FIFO. Queued entries are serialized as fixed 7-byte frames on a valid/ready byte stream for a UART or JTAG bridge. Overflow is counted, never stalls the processor.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
FILTER_R0, 1, when 1, writes to register 0 are ignored

Ports:
clock  in  1  single system clock (same clock as regfile_clock)
reset  in  1  asynchronous, active-high reset
trace_en  in  1  capture enable; 0 = ignore writeback activity
wb_en  in  1  regfile write enable (ctrl_writeEnable)
wb_reg  in  5  destination register (ctrl_writeReg)
wb_data  in  32  write data (data_writeReg)
wb_pc  in  12  instruction address (address_imem)
clear_stats  in  1  synchronous clear of drop_count and overflow
out_byte  out  8  serialized frame byte
out_valid  out  1  out_byte valid
out_ready  in  1  consumer accepts byte when high with out_valid
level  out  $clog2(DEPTH)+1  current FIFO occupancy
drop_count  out  8  saturating count of dropped captures
overflow  out  1  sticky: at least one capture dropped

Behaviour:
- Reset (async, any time, including mid-frame): FIFO emptied, level=0, out_valid=0, out_byte=0, drop_count=0, overflow=0, serializer to IDLE. The partial frame is discarded; no resume.
- Capture: on rising edge with trace_en & wb_en & !(FILTER_R0 & wb_reg==0), push entry {wb_reg, wb_pc, wb_data}.
- Push when FIFO full and no pop that cycle: entry dropped, drop_count+1 (saturates at 255), overflow<=1.
- Push when full with a pop in the same cycle: accepted, level unchanged.
- clear_stats: drop_count<=0, overflow<=0; if a drop occurs in the same cycle, the clear wins, then drop_count=1 and overflow=1.
- FIFO: circular buffer, read/write pointers wrap modulo DEPTH; level = pushes minus pops, 0..DEPTH.
- Serializer FSM:
  - IDLE: out_valid=0. If level>0, load head into the shift register, pop, and go to SEND with idx=0.
  - SEND: out_valid=1, out_byte = frame[idx]. On out_valid&out_ready: if idx==6, go to IDLE; else idx+1.
  - out_byte is held stable while out_valid & !out_ready.
- Frame format, sent in order:
  - b0 = {3'b101, reg[4:0]}
  - b1 = {4'b0000, pc[11:8]}
  - b2 = pc[7:0]
  - b3..b6 = data[31:24], [23:16], [15:8], [7:0]
- Latency: capture sampled at edge t0; serializer loads at edge t1; out_valid=1 after t1 (first byte visible 2 edges after the capture edge). One IDLE bubble cycle between consecutive frames.
- With out_ready held high, a frame takes 8 cycles (7 bytes plus 1 IDLE), so sustained throughput is one entry per 8 cycles.
- trace_en deassertion does not flush the queue; already-queued entries still drain.

Decomposition:
- Shared package wb_trace_pkg:
  - FRAME_BYTES=7
  - HDR_TAG=3'b101
  - ENTRY_W=49
  - entry struct {reg[4:0], pc[11:0], data[31:0]}
- Sub-module trace_fifo: synchronous, parameterized by DEPTH and ENTRY_W. Interface: push, pop, din, dout (head, combinational read), full, empty, level.
- Top level holds the capture filter, drop statistics, and serializer FSM.

Test Plan:
- Single capture: wb_reg=3, wb_pc=0x012, wb_data=0xDEADBEEF, out_ready=1 -> bytes A3,00,12,DE,AD,BE,EF; out_valid rises 2 edges after capture; level returns to 0.
- R0 filter: wb_en=1, wb_reg=0, FILTER_R0=1 -> no frame, level stays 0. Same stimulus with FILTER_R0=0 -> frame starting A0.
- Backpressure: out_ready=0 for 5 cycles mid-frame at b3 -> out_byte holds 0xDE, no byte skipped or repeated after release.
- Overflow: DEPTH=16, out_ready=0, 20 consecutive captures -> 1 entry in the serializer, level=16, drop_count=3, overflow=1. Then clear_stats -> both 0. Then 300 drops -> drop_count=255.
- Full push+pop: FIFO full, serializer loading in the same cycle as a capture -> capture accepted, drop_count unchanged, level stays 16.
- Async reset mid-frame at b4 -> out_valid=0 immediately, level=0. Next capture produces a clean frame starting at b0.
